// File: rtl/pipelined_addsub.sv
// Two-stage pipelined add/subtract with optional signed saturation.
// Stage 1 sums the low bits; stage 2 finishes the upper bits and registers the result and flags.
module pipelined_addsub #(
  parameter int WIDTH    = 32,
  parameter int LO_WIDTH = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_zero,
  input  logic             clear_sticky,
  output logic             sticky_overflow
);
  localparam int HI_WIDTH = WIDTH - LO_WIDTH;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic advance;

  logic                s1_valid_q,    s1_valid_d;
  logic [LO_WIDTH-1:0] s1_lo_sum_q,   s1_lo_sum_d;
  logic                s1_lo_carry_q, s1_lo_carry_d;
  logic [HI_WIDTH-1:0] s1_a_hi_q,     s1_a_hi_d;
  logic [HI_WIDTH-1:0] s1_b_hi_q,     s1_b_hi_d;
  logic                s1_sat_q,      s1_sat_d;

  logic             out_valid_q,    out_valid_d;
  logic [WIDTH-1:0] out_result_q,   out_result_d;
  logic             out_overflow_q, out_overflow_d;
  logic             out_carry_q,    out_carry_d;
  logic             out_zero_q,     out_zero_d;
  logic             sticky_q,       sticky_d;

  logic [WIDTH-1:0]  b_eff;
  logic [LO_WIDTH:0] lo_full;
  logic [HI_WIDTH:0] hi_full;
  logic [WIDTH-1:0]  raw_sum;
  logic              raw_ovf;

  // A full output register that is not being drained freezes the whole pipe.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin : stage1_comb
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    s1_valid_d    = s1_valid_q;
    s1_lo_sum_d   = s1_lo_sum_q;
    s1_lo_carry_d = s1_lo_carry_q;
    s1_a_hi_d     = s1_a_hi_q;
    s1_b_hi_d     = s1_b_hi_q;
    s1_sat_d      = s1_sat_q;

    // Subtract is A + ~B + 1; the +1 enters as carry-in at bit 0.
    b_eff   = in_op[0] ? ~in_b : in_b;
    lo_full = {1'b0, in_a[LO_WIDTH-1:0]} + {1'b0, b_eff[LO_WIDTH-1:0]}
            + {{LO_WIDTH{1'b0}}, in_op[0]};

    if (advance) begin
      s1_valid_d    = in_valid;
      s1_lo_sum_d   = lo_full[LO_WIDTH-1:0];
      s1_lo_carry_d = lo_full[LO_WIDTH];
      s1_a_hi_d     = in_a[WIDTH-1:LO_WIDTH];
      s1_b_hi_d     = b_eff[WIDTH-1:LO_WIDTH];
      s1_sat_d      = in_op[1];
    end
  end

  always_comb begin : stage2_comb
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_carry_d    = out_carry_q;
    out_zero_d     = out_zero_q;

    hi_full = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{HI_WIDTH{1'b0}}, s1_lo_carry_q};
    raw_sum = {hi_full[HI_WIDTH-1:0], s1_lo_sum_q};
    raw_ovf = (s1_a_hi_q[HI_WIDTH-1] == s1_b_hi_q[HI_WIDTH-1])
            & (raw_sum[WIDTH-1] != s1_a_hi_q[HI_WIDTH-1]);

    if (advance) begin
      out_valid_d = s1_valid_q;
      // Data registers only load real bundles, so they keep the last result across bubbles.
      if (s1_valid_q) begin
        if (s1_sat_q && raw_ovf) begin
          out_result_d = s1_a_hi_q[HI_WIDTH-1] ? SAT_NEG : SAT_POS;
        end else begin
          out_result_d = raw_sum;
        end
        out_overflow_d = raw_ovf;
        out_carry_d    = hi_full[HI_WIDTH];
        out_zero_d     = (out_result_d == '0);
      end
    end

    // Clear has priority over a same-cycle overflow delivery.
    sticky_d = sticky_q;
    if (clear_sticky) begin
      sticky_d = 1'b0;
    end else if (out_valid_q && out_ready && out_overflow_q) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_lo_sum_q    <= '0;
      s1_lo_carry_q  <= 1'b0;
      s1_a_hi_q      <= '0;
      s1_b_hi_q      <= '0;
      s1_sat_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_carry_q    <= 1'b0;
      out_zero_q     <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
      s1_valid_q     <= s1_valid_d;
      s1_lo_sum_q    <= s1_lo_sum_d;
      s1_lo_carry_q  <= s1_lo_carry_d;
      s1_a_hi_q      <= s1_a_hi_d;
      s1_b_hi_q      <= s1_b_hi_d;
      s1_sat_q       <= s1_sat_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_carry_q    <= out_carry_d;
      out_zero_q     <= out_zero_d;
      sticky_q       <= sticky_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_overflow    = out_overflow_q;
  assign out_carry       = out_carry_q;
  assign out_zero        = out_zero_q;
  assign sticky_overflow = sticky_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32): directed vectors, corner sequences,
// and random traffic scored against an arithmetic reference model.
module tb_pipelined_addsub;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_carry, out_zero;
  logic        clear_sticky, sticky_overflow;

  pipelined_addsub dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_op          (in_op),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_carry      (out_carry),
    .out_zero       (out_zero),
    .clear_sticky   (clear_sticky),
    .sticky_overflow(sticky_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        carry;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        ovf;
    logic        carry;
    logic        zero;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic sticky_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    exp_t   e;
    longint sa, sb, ua, ub, st;
    logic [31:0] raw;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    st = op[0] ? sa - sb : sa + sb;
    raw = op[0] ? a - b : a + b;
    e.ovf   = (st > SMAX) || (st < SMIN);
    e.carry = op[0] ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
    if (op[1] && e.ovf) e.res = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else                e.res = raw;
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Scoreboard: handshakes seen at the falling edge commit at the next rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      exp_t e;
      logic nxt;
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      check("sticky_model", sticky_overflow, sticky_m);
      nxt = sticky_m;
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_ovf", out_overflow, e.ovf);
          check("sb_carry", out_carry, e.carry);
          check("sb_zero", out_zero, e.zero);
          if (e.ovf) nxt = 1'b1;
        end
      end
      if (clear_sticky) nxt = 1'b0;
      sticky_m = nxt;
      if (in_valid && in_ready) sb_q.push_back(model(in_a, in_b, in_op));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("send_accept", ok, 1);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int t = 0; t < 30 && sb_q.size() != 0; t++) begin
      @(posedge clock); #1;
    end
    check(name, sb_q.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_FFFF;
      5:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  vec_t        vecs[10];
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'h7FFF_FFFF, 32'h1,         2'b00, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h1,         2'b10, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h5,         32'h7,         2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h1,         2'b11, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_FFFF, 32'h1,         2'b00, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h1,         2'b00, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{32'h7,         32'h7,         2'b01, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{32'h0,         32'h0,         2'b11, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{32'h1234_5678, 32'h0000_1111, 2'b00, 32'h1234_6789, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; clear_sticky = 1'b0;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {out_overflow, out_carry, out_zero}, 0);
    check("rst_sticky", sticky_overflow, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors, one at a time, checking the 2-cycle latency.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      @(negedge clock);
      check("lat_stage1", out_valid, 0);
      @(negedge clock);
      check("lat_stage2", out_valid, 1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_ovf", out_overflow, vecs[i].ovf);
      check("vec_carry", out_carry, vecs[i].carry);
      check("vec_zero", out_zero, vecs[i].zero);
      @(posedge clock); #1;
    end

    // Backpressure: 4 back-to-back bundles, consumer stalls 3 cycles mid-stream.
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(32'h1111_1111 * i, 32'(i * 3), 2'(i));
      end
      begin
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        held = out_result;
        check("bp_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        repeat (2) begin
          @(negedge clock);
          check("bp_hold", out_result, held);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clock); #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with two bundles in flight.
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, 2'b00);
    send(32'h0000_0003, 32'h4, 2'b00);
    #2 reset_n = 1'b0;
    sb_q.delete();
    sticky_m = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_sticky", sticky_overflow, 0);
    check("rstmid_result", out_result, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("rstmid_no_stale", out_valid, 0);
    end
    @(posedge clock); #1;
    send(32'h0000_0010, 32'h0000_0020, 2'b00);
    drain("rstmid_drain");

    // Sticky: set, then clear coincident with an overflow delivery, then set again.
    send(32'h7FFF_FFFF, 32'h1, 2'b00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("sticky_set", sticky_overflow, 1);
    @(posedge clock); #1;
    send(32'h7FFF_FFFF, 32'h1, 2'b10);
    @(posedge clock); #1 clear_sticky = 1'b1;
    @(posedge clock); #1 clear_sticky = 1'b0;
    @(negedge clock);
    check("sticky_clear_wins", sticky_overflow, 0);
    @(posedge clock); #1;
    send(32'h8000_0000, 32'h8000_0000, 2'b00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("sticky_reset", sticky_overflow, 1);
    @(posedge clock); #1;

    // Random traffic with random backpressure and occasional clears.
    for (int c = 0; c < 600; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_a         = pick();
      in_b         = pick();
      in_op        = 2'($urandom_range(0, 3));
      out_ready    = ($urandom_range(0, 9) < 7);
      clear_sticky = ($urandom_range(0, 19) == 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    clear_sticky = 1'b0;
    drain("rand_drain");
    repeat (2) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values are even and at least 4.
REQ-002 Parameter LO_WIDTH, default WIDTH/2, bits summed in stage 1; legal range is 1..WIDTH-1.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operand bundle present.
REQ-006 in_ready  output  1  block accepts bundle this cycle.
REQ-007 in_a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_op  input  2  00 add, 01 sub, 10 saturating add, 11 saturating sub.
REQ-010 out_valid  output  1  result bundle present.
REQ-011 out_ready  input  1  consumer takes bundle this cycle.
REQ-012 out_result  output  WIDTH  result.
REQ-013 out_overflow  output  1  signed overflow of the unsaturated sum.
REQ-014 out_carry  output  1  unsigned carry-out; for sub, 1 = no borrow (A >= B unsigned).
REQ-015 out_zero  output  1  out_result == 0.
REQ-016 clear_sticky  input  1  synchronous clear of sticky_overflow.
REQ-017 sticky_overflow  output  1  set when any delivered result had out_overflow = 1.

Function
REQ-018 Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
REQ-019 Pipeline: stage 1 registers the low LO_WIDTH sum bits, the low-part carry, the upper operand bits and the op; stage 2 computes the upper bits with the registered carry and drives the outputs.
REQ-020 Latency: exactly 2 cycles from accept to out_valid when out_ready stays 1; throughput is one bundle per cycle.
REQ-021 Advance: advance = ~out_valid | out_ready; both stages move only on advance, and in_ready = advance.
REQ-022 Stall: while out_valid=1 and out_ready=0, all output and stage-1 registers hold; no bundle is dropped, duplicated or reordered.
REQ-023 Bubbles: stage-1 valid is set to in_valid & in_ready on advance; out_valid takes stage-1 valid on advance.
REQ-024 Sub: uses A + ~B + 1, with carry-in 1 injected at bit 0 of stage 1.
REQ-025 Overflow: (A[W-1] == B'[W-1]) & (S[W-1] != A[W-1]), where B' is B or ~B for sub and S is the raw sum.
REQ-026 Carry: out_carry is the carry out of bit WIDTH-1 of the raw sum, including the sub carry-in.
REQ-027 Saturation (op 1x): if overflow, the result is 0x7F..F when A[W-1]=0, otherwise 0x80..0; with no overflow it equals the raw sum.
REQ-028 Saturation flags: out_overflow and out_carry always report the raw sum, even in saturating modes.
REQ-029 Zero flag: out_zero is computed on the final (possibly saturated) out_result.
REQ-030 Sticky: sticky_overflow sets on an output transfer with out_overflow=1.
REQ-031 Sticky simultaneous events: clear_sticky wins over a same-cycle set.
REQ-032 Datapath holding: output data registers hold their last value when out_valid=0; consumers qualify data with out_valid.
REQ-033 No combinational path from in_valid, in_a, in_b or in_op to any output.
REQ-034 in_ready depends combinationally on out_ready only.

Reset
REQ-035 Assertion: on reset_n low, stage-1 valid, out_valid, out_result, out_overflow, out_carry, out_zero and sticky_overflow go to 0 immediately, regardless of clock.
REQ-036 In-flight bundles: reset discards any in-flight bundle; the first output after release comes from an input accepted after release.
REQ-037 Ready: in_ready = 1 during and after reset, because out_valid = 0.

Verification
REQ-038 Overflow, WIDTH=32: A=0x7FFFFFFF, B=1, op 00 -> result 0x80000000, ovf 1, carry 0, zero 0; same with op 10 -> 0x7FFFFFFF, ovf 1.
REQ-039 Borrow and saturation: A=5, B=7, op 01 -> 0xFFFFFFFE, ovf 0, carry 0; A=0x80000000, B=1, op 11 -> 0x80000000, ovf 1, carry 1.
REQ-040 Carry across the stage split: A=0x0000FFFF, B=1, op 00 -> 0x00010000, carry 0; A=0xFFFFFFFF, B=1 -> 0x00000000, carry 1, zero 1.
REQ-041 Backpressure: 4 back-to-back bundles with out_ready held 0 for 3 cycles mid-stream -> all 4 delivered in order, values unchanged; in_ready=0 exactly while out_valid & ~out_ready.
REQ-042 Reset mid-flight: reset_n pulsed low with 2 bundles in flight -> out_valid 0 asynchronously, sticky 0, no stale bundle appears after release.
REQ-043 Sticky priority: overflow output transfer in the same cycle as clear_sticky=1 -> sticky_overflow 0; the next overflow transfer -> 1.
